// File: rtl/bitcoin_sha256d_engine_if.sv
// bitcoin_sha256d_engine_if: tt_um user pins between the host and the engine.
// ena/ui_in/uio_in flow toward the engine; uo_out/uio_out/uio_oe flow back.
interface bitcoin_sha256d_engine_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/bitcoin_sha256d_engine.sv
// bitcoin_sha256d_engine: SHA256(SHA256(header)) of an 80-byte header, tt_um pins.
// Define SHA_TWO_ROUND_EN to run two compression rounds per clock.
module bitcoin_sha256d_engine (
    input  logic clk,
    input  logic rst_n,
    bitcoin_sha256d_engine_if.slave bus
);
    typedef enum logic [2:0] {
        LOAD_REQ, LOAD_WAIT, HASH1A, HASH1B,
        HASH2, RD_REQ, RD_WAIT, FINISHED
    } state_t;

    typedef enum logic [1:0] {ST_LOAD, ST_ROUND, ST_FEED} step_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef SHA_TWO_ROUND_EN
    localparam logic [5:0] RSTEP = 6'd2;
    localparam logic [5:0] RLAST = 6'd62;
`else
    localparam logic [5:0] RSTEP = 6'd1;
    localparam logic [5:0] RLAST = 6'd63;
`endif

    function automatic logic [31:0] bsig0(logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Working state packed as {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] rnd_f(
        logic [255:0] s, logic [31:0] k, logic [31:0] wt
    );
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + wt;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(logic [255:0] x, logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++)
            r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        return r;
    endfunction

    function automatic logic [7:0] byte_at(logic [255:0] d, logic [4:0] k);
        logic [255:0] t;
        t = d << {k, 3'b000};
        return t[255:248];
    endfunction

    state_t       state;
    step_t        step;
    logic [5:0]   idx;
    logic [5:0]   rnd;
    logic         rq;
    logic         done;
    logic [7:0]   oe;
    logic [7:0]   dout;
    logic [639:0] block;
    logic [255:0] hv;
    logic [255:0] st;
    logic [31:0]  w [16];
    logic [255:0] st_nx;
    logic [255:0] hv_ff;
    logic [31:0]  w_a;
`ifdef SHA_TWO_ROUND_EN
    logic [31:0]  w_b;
`endif
    logic [511:0] msg;
    logic         ack;
    logic         unused;

    assign ack = bus.ui_in[7];
    assign unused = bus.ena;
    assign bus.uo_out = {rq, done, idx};
    assign bus.uio_out = dout;
    assign bus.uio_oe = oe;
    assign hv_ff = add8(hv, st);

    always_comb begin
        case (state)
            HASH1B:  msg = {block[127:0], 8'h80, 312'd0, 64'd640};
            HASH2:   msg = {hv, 8'h80, 184'd0, 64'd256};
            default: msg = block[639:128];
        endcase
    end

    // w[0] is W[t]; new entries extend the window by one schedule step each.
    always_comb begin
        w_a = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
`ifdef SHA_TWO_ROUND_EN
        w_b = ssig1(w[15]) + w[10] + ssig0(w[2]) + w[1];
        st_nx = rnd_f(rnd_f(st, K[rnd], w[0]), K[rnd | 6'd1], w[1]);
`else
        st_nx = rnd_f(st, K[rnd], w[0]);
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= LOAD_REQ;
            step  <= ST_LOAD;
            idx   <= '0;
            rnd   <= '0;
            rq    <= 1'b0;
            done  <= 1'b0;
            oe    <= '0;
            dout  <= '0;
            block <= '0;
            hv    <= '0;
            st    <= '0;
            for (int j = 0; j < 16; j++) w[j] <= '0;
        end else begin
            unique case (state)
                LOAD_REQ: begin
                    if (!rq) begin
                        rq <= 1'b1;
                    end else begin
                        // Words arrive in order, so shifting in lands word i
                        // at block[639-16*i -: 16] once all 40 are in.
                        block <= {block[623:0], bus.ui_in, bus.uio_in};
                        rq    <= 1'b0;
                        state <= (idx == 6'd39) ? HASH1A : LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    idx   <= idx + 6'd1;
                    rq    <= 1'b1;
                    state <= LOAD_REQ;
                end
                HASH1A, HASH1B, HASH2: begin
                    unique case (step)
                        ST_LOAD: begin
                            for (int j = 0; j < 16; j++)
                                w[j] <= msg[511 - 32*j -: 32];
                            st <= (state == HASH1B) ? hv : IV;
                            if (state != HASH1B) hv <= IV;
                            rnd  <= '0;
                            step <= ST_ROUND;
                        end
                        ST_ROUND: begin
                            st <= st_nx;
`ifdef SHA_TWO_ROUND_EN
                            for (int j = 0; j < 14; j++) w[j] <= w[j+2];
                            w[14] <= w_a;
                            w[15] <= w_b;
`else
                            for (int j = 0; j < 15; j++) w[j] <= w[j+1];
                            w[15] <= w_a;
`endif
                            rnd <= rnd + RSTEP;
                            if (rnd == RLAST) step <= ST_FEED;
                        end
                        ST_FEED: begin
                            hv   <= hv_ff;
                            step <= ST_LOAD;
                            if (state == HASH1A) begin
                                state <= HASH1B;
                            end else if (state == HASH1B) begin
                                state <= HASH2;
                            end else begin
                                state <= RD_REQ;
                                done  <= 1'b1;
                                oe    <= 8'hff;
                                idx   <= '0;
                                dout  <= hv_ff[255:248];
                            end
                        end
                        default: step <= ST_LOAD;
                    endcase
                end
                RD_REQ: begin
                    if (!rq) begin
                        if (!ack) rq <= 1'b1;
                    end else if (ack) begin
                        rq  <= 1'b0;
                        idx <= idx + 6'd1;
                        if (idx == 6'd31) begin
                            state <= FINISHED;
                            dout  <= 8'h00;
                        end else begin
                            state <= RD_WAIT;
                            dout  <= byte_at(hv, idx[4:0] + 5'd1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (!ack) begin
                        rq    <= 1'b1;
                        state <= RD_REQ;
                    end
                end
                FINISHED: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitcoin_sha256d_engine.sv
// tb_bitcoin_sha256d_engine: header/digest vector table plus random headers,
// checked against a byte-level SHA-256 reference model.
module tb_bitcoin_sha256d_engine;
    typedef logic [7:0] bytes_t [$];

    typedef struct {
        logic [639:0] hdr;
        logic [255:0] dig;
        bit           hold;
    } vec_t;

    localparam logic [639:0] GEN_HDR = {
        32'h01000000,
        256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        96'h29ab5f49ffff001d1dac2b7c
    };
    localparam logic [255:0] GEN_DIG =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

`ifdef SHA_TWO_ROUND_EN
    localparam int LAT_MAX = 110;
`else
    localparam int LAT_MAX = 200;
`endif

    localparam logic [31:0] IV_W [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [5];

    bitcoin_sha256d_engine_if bus ();

    bitcoin_sha256d_engine dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input bytes_t m);
        bytes_t      p;
        logic [63:0] nbits;
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1, ch, mj;
        p = m;
        nbits = 64'(m.size()) * 64'd8;
        for (int i = 0; i < 8; i++) h[i] = IV_W[i];
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(nbits[8*i +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) begin
                    w[t] = {p[64*b+4*t], p[64*b+4*t+1],
                            p[64*b+4*t+2], p[64*b+4*t+3]};
                end else begin
                    s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                    s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                    w[t] = w[t-16] + s0 + w[t-7] + s1;
                end
            end
            for (int i = 0; i < 8; i++) v[i] = h[i];
            for (int t = 0; t < 64; t++) begin
                s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
                ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
                t1 = v[7] + s1 + ch + K[t] + w[t];
                s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
                mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
                t2 = s0 + mj;
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] sha256d(input logic [639:0] hdr);
        bytes_t       q;
        logic [255:0] d1;
        for (int i = 0; i < 80; i++) q.push_back(hdr[639 - 8*i -: 8]);
        d1 = sha256(q);
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(d1[255 - 8*i -: 8]);
        return sha256(q);
    endfunction

    task automatic check(input string name, input logic [639:0] act,
                         input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_rq(input logic lvl, output bit ok);
        int n = 0;
        while (bus.uo_out[7] !== lvl && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.uo_out[7] === lvl);
    endtask

    task automatic load_words(input logic [639:0] hdr, input int nw);
        bit ok;
        for (int k = 0; k < nw; k++) begin
            wait_rq(1'b1, ok);
            if (!ok) begin
                check("load_rq_timeout", 640'(0), 640'(1));
                return;
            end
            check("load_addr", 640'(bus.uo_out[5:0]), 640'(k));
            if (k == 0) check("load_oe", 640'(bus.uio_oe), 640'(0));
            {bus.ui_in, bus.uio_in} = hdr[639 - 16*k -: 16];
            @(negedge clk);
        end
    endtask

    task automatic read_digest(input bit hold, output logic [255:0] d);
        bit ok;
        bit stay;
        d = '0;
        bus.ui_in = 8'h00;
        for (int k = 0; k < 32; k++) begin
            wait_rq(1'b1, ok);
            if (!ok) begin
                check("rd_rq_timeout", 640'(0), 640'(1));
                return;
            end
            check("rd_addr", 640'(bus.uo_out[5:0]), 640'(k));
            if (k == 0) check("rd_oe", 640'(bus.uio_oe), 640'(8'hff));
            d[255 - 8*k -: 8] = bus.uio_out;
            bus.ui_in = 8'h80;
            wait_rq(1'b0, ok);
            if (!ok) begin
                check("rd_drop_timeout", 640'(0), 640'(1));
                return;
            end
            check("rd_step", 640'(bus.uo_out[5:0]), 640'(k + 1));
            if (hold) begin
                stay = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.uo_out[7] !== 1'b0) stay = 1'b0;
                    if (bus.uo_out[5:0] !== 6'(k + 1)) stay = 1'b0;
                end
                check("ack_hold", 640'(stay), 640'(1));
            end
            bus.ui_in = 8'h00;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int           n;
        logic [255:0] d;
        load_words(v.hdr, 40);
        check("block", dut.block, v.hdr);
        n = 0;
        while (bus.uo_out[6] !== 1'b1 && n < 400) begin
            bus.ui_in  = 8'($urandom());
            bus.uio_in = 8'($urandom());
            @(negedge clk);
            n++;
        end
        check("done_latency", 640'(n <= LAT_MAX && bus.uo_out[6] === 1'b1),
              640'(1));
        if (bus.uo_out[6] !== 1'b1) return;
        read_digest(v.hold, d);
        check("digest", 640'(d), 640'(v.dig));
        repeat (5) @(negedge clk);
        check("final_uo", 640'(bus.uo_out), 640'(8'h60));
        check("final_uio", 640'(bus.uio_out), 640'(0));
    endtask

    initial begin
        logic [639:0] h;
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.ui_in = 8'h00;
        bus.uio_in = 8'h00;

        vecs[0].hdr = GEN_HDR;
        vecs[0].dig = GEN_DIG;
        vecs[0].hold = 1'b0;
        vecs[1].hdr = '0;
        vecs[1].dig = sha256d('0);
        vecs[1].hold = 1'b0;
        for (int v = 2; v < 5; v++) begin
            for (int i = 0; i < 20; i++) h[32*i +: 32] = $urandom();
            vecs[v].hdr = h;
            vecs[v].dig = sha256d(h);
            vecs[v].hold = (v == 3);
        end
        check("model_genesis", 640'(sha256d(GEN_HDR)), 640'(GEN_DIG));

        repeat (3) @(negedge clk);
        check("rst_uo", 640'(bus.uo_out), 640'(0));
        check("rst_uio", 640'(bus.uio_out), 640'(0));
        check("rst_oe", 640'(bus.uio_oe), 640'(0));
        check("rst_block", dut.block, 640'(0));
        rst = 1'b0;
        @(negedge clk);
        check("first_uo", 640'(bus.uo_out), 640'(8'h80));
        check("first_oe", 640'(bus.uio_oe), 640'(0));

        load_words(GEN_HDR, 18);
        rst = 1'b1;
        #1;
        check("abort_uo", 640'(bus.uo_out), 640'(0));
        check("abort_oe", 640'(bus.uio_oe), 640'(0));
        check("abort_block", dut.block, 640'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                rst = 1'b1;
                bus.ui_in = 8'h00;
                bus.uio_in = 8'h00;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            run_vec(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitcoin_sha256d_engine.md
Name: bitcoin_sha256d_engine

Overview:
- Computes the Bitcoin double SHA-256, SHA256(SHA256(header)), of one 80-byte block header.
- Sits in the Tiny Tapeout user slot (tt_um pin set). The header is loaded as 40 16-bit words over a request handshake.
- The 32-byte digest is read back one byte per handshake.
- Hashing is iterative, one SHA-256 round per clock.

Parameters:
- None. Header length (80 B), word count (40) and digest length (32 B) are fixed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous and active-high (1 = reset), despite the legacy name.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  load phase: word bits [15:8]. Read phase: bit 7 = ACK from host.
- uio_in  in  8  load phase: word bits [7:0].
- uo_out  out  8  [5:0] ADDR, [6] DONE, [7] RQ.
- uio_out  out  8  read phase: digest byte at ADDR; 0 otherwise.
- uio_oe  out  8  0x00 in load/hash phases; 0xFF in read phase.

Behaviour:
- Reset: all outputs are 0, FSM in LOAD, word index 0, 640-bit internal register `block` cleared.
- Reset mid-operation aborts everything immediately.

States: LOAD_REQ -> LOAD_WAIT -> HASH1A -> HASH1B -> HASH2 -> RD_REQ -> RD_WAIT -> FINISHED.

Load phase:
- ADDR = word index (0..39).
- LOAD_REQ: drive RQ=1. At the next posedge, capture {ui_in, uio_in} into block[639-16*i -: 16], drop RQ, and go to LOAD_WAIT.
- LOAD_WAIT: hold RQ=0 for exactly one cycle, then increment i.
- After word 39 is captured, go to HASH1A.

Ordering:
- Word 0 holds header bytes 0 (high) and 1 (low).
- block[639:632] is header byte 0; SHA input byte order is block MSB first.

Hashing:
- HASH1A: compress block[639:128] (64 B) starting from the standard SHA-256 IV.
- HASH1B: compress block[127:0] followed by padding 0x80, zeros, and 64-bit length 640.
- HASH2: compress the 32-byte digest followed by padding 0x80, zeros, and length 256, starting from the IV.
- Each compression takes 1 load cycle, 64 round cycles and 1 feed-forward cycle (66 cycles).
- The message schedule is a 16-word sliding window.
- All arithmetic is mod 2^32.
- DONE rises no later than 200 cycles after word 39 is captured.

Read phase:
- DONE=1, held until reset. uio_oe=0xFF. ADDR starts at 0.
- Digest byte k is big-endian byte k of the final H0..H7 (byte 0 = H0[31:24]).
- RD_REQ: requires ui_in[7]=0; then RQ=1 with ADDR and uio_out stable.
- While RQ=1, the FSM waits for ui_in[7]=1. It then drops RQ and increments ADDR.
- RD_WAIT: waits for ui_in[7]=0 before the next request (four-phase handshake).
- After byte 31 is acknowledged, ADDR=32, RQ stays 0, and the FSM enters FINISHED.
- FINISHED: DONE=1, ADDR=32, uio_out=0. It stays there until reset; there is no auto-restart.
- ui_in[7] is ignored outside the read phase. Data inputs are ignored outside LOAD_REQ.

Optional Feature:
- SHA_TWO_ROUND_EN defined: two SHA-256 rounds per clock. Each compression takes 34 cycles and DONE arrives within 110 cycles of the last word.
- Not defined: one round per clock, as above.
- Digest, ports and handshakes are identical either way.

Test Plan:
- Genesis header 0100000000…003BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A29AB5F49FFFF001D1DAC2B7C loaded as 40 words -> internal `block` equals the header.
- Same header -> 32 bytes read back give 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000; ADDR ends at 32; DONE=1.
- Reset held, then released -> uo_out=0x80 (RQ=1, ADDR=0) on the first cycle; uio_oe=0x00.
- Reset asserted after word 17 -> outputs 0; the reload of the full header then yields the correct digest.
- Host holds ACK high in the read phase -> RQ is not reasserted until ACK=0; ADDR advances by exactly 1 per handshake.
- All-zero header -> digest equals SHA256(SHA256(80 zero bytes)) from a software model; DONE latency is 200 cycles or fewer.
